// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter sequencer with an integrated return stack and a
//   prioritised N-channel interrupt entry unit. Each step it resolves the
//   next fetch address from the decoded op, ALU flags and pending IRQs.
//
//   Build option: define PCSEQ_NEST_EN to allow a higher-priority channel
//   to interrupt an active handler. Without it, no channel is accepted
//   while any handler is in service.
//
//   Ports:
//     clk, rst         clock, asynchronous active-low reset
//     step             execute the current op this cycle
//     op               control op (NOP/JEQ/JGT/JLT/JMP/NEX/CALL/RET/RETI/EI/DI)
//     eq, gt, lt, aeq  ALU flags
//     hlt              holds the PC on NEX
//     target           immediate jump/call target
//     reg_target       indirect target, used when target is zero
//     irq              level interrupt requests, channel 0 highest priority
//     clr_err          clears the sticky stack error flags
//     pc               current fetch address
//     ret_top          top stack entry, 0 when the stack is empty
//     depth            stack occupancy
//     in_service       channels whose handlers are active
//     irq_ack          one-hot, one-cycle acknowledge pulse
//     eoi              one-cycle end-of-interrupt pulse
//     int_en           global interrupt enable
//     stk_ovf, stk_unf sticky stack overflow / underflow flags
module pc_sequencer #(
   parameter int AW       = 15,
   parameter int DEPTH    = 16,
   parameter int NCH      = 4,
   parameter int VEC_BASE = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     step,
   input  logic [3:0]               op,
   input  logic                     eq,
   input  logic                     gt,
   input  logic                     lt,
   input  logic                     aeq,
   input  logic                     hlt,
   input  logic [AW-1:0]            target,
   input  logic [AW-1:0]            reg_target,
   input  logic [NCH-1:0]           irq,
   input  logic                     clr_err,
   output logic [AW-1:0]            pc,
   output logic [AW-1:0]            ret_top,
   output logic [$clog2(DEPTH):0]   depth,
   output logic [NCH-1:0]           in_service,
   output logic [NCH-1:0]           irq_ack,
   output logic                     eoi,
   output logic                     int_en,
   output logic                     stk_ovf,
   output logic                     stk_unf
);

   localparam int AI = $clog2(DEPTH);
   localparam int DW = AI + 1;
   localparam logic [DW-1:0] FULL = DW'(DEPTH);

   localparam logic [3:0] OP_JEQ  = 4'd1;
   localparam logic [3:0] OP_JGT  = 4'd2;
   localparam logic [3:0] OP_JLT  = 4'd3;
   localparam logic [3:0] OP_JMP  = 4'd5;
   localparam logic [3:0] OP_NEX  = 4'd6;
   localparam logic [3:0] OP_CALL = 4'd7;
   localparam logic [3:0] OP_RET  = 4'd8;
   localparam logic [3:0] OP_RETI = 4'd9;
   localparam logic [3:0] OP_EI   = 4'd10;
   localparam logic [3:0] OP_DI   = 4'd11;

   logic [AW-1:0]  stack_mem [DEPTH];
   logic [NCH-1:0] pending;
   logic [3:0]     cand_idx;
   logic           outranks;
   logic           accept;
   logic [NCH-1:0] acc_bit;
   logic [NCH-1:0] isr_low_bit;
   logic [AW-1:0]  pc_inc;
   logic [AW-1:0]  jmp_dst;
   logic [AW-1:0]  vec;
   logic [AW-1:0]  pc_nxt;
   logic [AW-1:0]  push_val;
   logic           push;
   logic           pop;
   logic           set_ovf;
   logic           set_unf;
   logic           reti_clr;
   logic           ie_nxt;
   logic           stk_empty;
   logic           stk_full;

   assign stk_empty = (depth == '0);
   assign stk_full  = (depth == FULL);
   assign ret_top   = stk_empty ? '0 : stack_mem[AI'(depth - DW'(1))];

   // Lowest set pending bit; NCH means "none".
   always_comb begin
      cand_idx = 4'(NCH);
      for (int unsigned i = NCH; i > 0; i--) begin
         if (pending[i-1]) cand_idx = 4'(i - 1);
      end
   end

`ifdef PCSEQ_NEST_EN
   logic [3:0] isr_idx;

   // Lowest active handler index; NCH when idle so any candidate outranks it.
   always_comb begin
      isr_idx = 4'(NCH);
      for (int unsigned i = NCH; i > 0; i--) begin
         if (in_service[i-1]) isr_idx = 4'(i - 1);
      end
   end

   assign outranks = (cand_idx < isr_idx);
`else
   assign outranks = (in_service == '0);
`endif

   assign accept      = step & int_en & ~stk_full & (pending != '0) & outranks;
   assign acc_bit     = accept ? (NCH'(1) << cand_idx) : '0;
   // Two's-complement trick isolates the lowest set in_service bit.
   assign isr_low_bit = in_service & (~in_service + NCH'(1));
   assign pc_inc      = pc + AW'(1);
   assign jmp_dst     = (target == '0) ? reg_target : target;
   assign vec         = AW'(VEC_BASE) + AW'(cand_idx);

   always_comb begin
      pc_nxt   = pc;
      push     = 1'b0;
      pop      = 1'b0;
      push_val = pc;
      set_ovf  = 1'b0;
      set_unf  = 1'b0;
      reti_clr = 1'b0;
      ie_nxt   = int_en;
      if (accept) begin
         // Interrupt entry replaces the op: return to the un-executed op.
         push     = 1'b1;
         push_val = pc;
         pc_nxt   = vec;
      end else if (step) begin
         case (op)
            OP_JEQ:  pc_nxt = eq ? target : pc_inc;
            OP_JGT:  pc_nxt = (gt | (aeq & eq)) ? target : pc_inc;
            OP_JLT:  pc_nxt = (lt | (aeq & eq)) ? target : pc_inc;
            OP_JMP:  pc_nxt = jmp_dst;
            OP_NEX:  pc_nxt = hlt ? pc : pc_inc;
            OP_CALL: begin
               if (!stk_full) begin
                  push     = 1'b1;
                  push_val = pc_inc;
                  pc_nxt   = jmp_dst;
               end else begin
                  pc_nxt  = pc_inc;
                  set_ovf = 1'b1;
               end
            end
            OP_RET, OP_RETI: begin
               if (!stk_empty) begin
                  pop    = 1'b1;
                  pc_nxt = ret_top;
               end else begin
                  pc_nxt  = pc_inc;
                  set_unf = 1'b1;
               end
               reti_clr = (op == OP_RETI) && (in_service != '0);
            end
            OP_EI: begin
               ie_nxt = 1'b1;
               pc_nxt = pc_inc;
            end
            OP_DI: begin
               ie_nxt = 1'b0;
               pc_nxt = pc_inc;
            end
            default: pc_nxt = pc;
         endcase
      end
   end

   // Stack storage needs no reset: entries above depth are never read.
   always_ff @(posedge clk) begin
      if (push) stack_mem[AI'(depth)] <= push_val;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc         <= '0;
         depth      <= '0;
         pending    <= '0;
         in_service <= '0;
         irq_ack    <= '0;
         eoi        <= 1'b0;
         int_en     <= 1'b1;
         stk_ovf    <= 1'b0;
         stk_unf    <= 1'b0;
      end else begin
         pc         <= pc_nxt;
         pending    <= (pending | irq) & ~acc_bit;
         in_service <= (in_service | acc_bit) & ~(reti_clr ? isr_low_bit : '0);
         irq_ack    <= acc_bit;
         eoi        <= reti_clr;
         int_en     <= ie_nxt;
         if (push)     depth <= depth + DW'(1);
         else if (pop) depth <= depth - DW'(1);
         if (set_ovf)      stk_ovf <= 1'b1;
         else if (clr_err) stk_ovf <= 1'b0;
         if (set_unf)      stk_unf <= 1'b1;
         else if (clr_err) stk_unf <= 1'b0;
      end
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer with an integrated return stack and a prioritised, optionally nesting, N-channel interrupt entry unit. It sits between the instruction decoder and instruction memory: each `step` it resolves the next fetch address from the decoded control op, ALU flags and interrupt requests. It is the generalised successor of the fixed 15-bit, 3-IRQ counter, with configurable width, stack depth and channel count, in-service tracking, and stack error detection.

## Interface
- `AW`, 15: program address width.
- `DEPTH`, 16: return-stack entries; power of two, 2..256.
- `NCH`, 4: interrupt channels, 1..8; channel 0 has the highest priority.
- `VEC_BASE`, 1: address of the channel 0 vector; channel k vectors to `VEC_BASE+k`, truncated to AW.
- `clk  in  1`: clock; all state changes on its rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `step  in  1`: execute the current op this cycle.
- `op  in  4`: NOP=0, JEQ=1, JGT=2, JLT=3, JMP=5, NEX=6, CALL=7, RET=8, RETI=9, EI=10, DI=11; other codes behave as NOP.
- `eq`, `gt`, `lt`, `aeq`  in  1 each: ALU flags.
- `hlt  in  1`: holds the PC on NEX.
- `target  in  AW`: immediate jump/call target.
- `reg_target  in  AW`: indirect target, used when `target==0`.
- `irq  in  NCH`: level interrupt requests.
- `clr_err  in  1`: clears the sticky error flags.
- `pc  out  AW`: current fetch address.
- `ret_top  out  AW`: top stack entry; 0 when the stack is empty.
- `depth  out  $clog2(DEPTH)+1`: stack occupancy.
- `in_service  out  NCH`: channels whose handlers are currently active.
- `irq_ack  out  NCH`: one-hot, one-cycle acknowledge pulse.
- `eoi  out  1`: one-cycle end-of-interrupt pulse.
- `int_en  out  1`: global interrupt enable.
- `stk_ovf`, `stk_unf  out  1 each`: sticky error flags.

## Operation
- Reset values: `pc`=0, `depth`=0, `ret_top`=0, `in_service`=0, `pending`=0, `irq_ack`=0, `eoi`=0, `int_en`=1, `stk_ovf`=0, `stk_unf`=0.
- Pending register: `pending |= irq` every cycle. The bit for channel k clears on acceptance of channel k.
- Candidate channel: the lowest-index set bit of `pending`.
- The candidate is accepted when all of these hold:
  - `step` is high;
  - `int_en` is high;
  - `depth<DEPTH`;
  - it outranks every `in_service` bit, i.e. its index is lower than the lowest set `in_service` index, or `in_service` is 0.
- Accept action:
  - the current op is not executed;
  - push `pc`;
  - set `pc` to the channel's vector;
  - set the channel's `in_service` bit;
  - pulse `irq_ack[k]`.
- With no acceptance and `step` high, the op executes as follows.
- JEQ: jump if `eq`.
- JGT: jump if `gt | (aeq & eq)`.
- JLT: jump if `lt | (aeq & eq)`.
- For the three conditional jumps, the jump destination is `target`; not taken gives `pc+1`.
- JMP: `pc` = `target`, or `reg_target` if `target==0`.
- NEX: `pc+1`, or hold if `hlt`.
- CALL:
  - stack not full: push `pc+1`, then jump as JMP;
  - stack full: no push, `pc+1`, set `stk_ovf`.
- RET:
  - stack not empty: pop, `pc` = popped value;
  - stack empty: `pc+1`, set `stk_unf`.
- RETI: RET, plus:
  - clear the lowest set `in_service` bit and pulse `eoi`;
  - if `in_service` is 0, no clear and no `eoi`.
- EI / DI: `int_en` = 1 / 0, then `pc+1`.
- NOP: hold `pc`.
- With `step` low: `pc`, the stack and `in_service` hold; `pending` still accumulates.
- Arithmetic: `pc+1` and vector addition wrap modulo 2^AW.
- `clr_err` clears both sticky flags. Setting a flag in the same cycle as `clr_err` wins.

## Timing
- All outputs are registered. The `pc` for an op executed at edge n is visible after edge n.
- `ret_top` and `depth` reflect a push or pop after the same edge.
- An `irq` asserted at cycle n is first eligible for acceptance at the step edge of cycle n+1; accept latency is 1 clock.
- `irq_ack` and `eoi` are high for exactly the cycle after the accepting/RETI edge, aligned with the new `pc`.
- A DI and a pending IRQ at the same step: the IRQ is taken, because the op does not execute.
- Reset asserted mid-operation returns all state to reset values immediately. Stack memory contents are don't-care because `depth` is 0.

## Configuration
- `PCSEQ_NEST_EN` defined: interrupt nesting by priority as described under Operation.
- `PCSEQ_NEST_EN` undefined:
  - no acceptance while `in_service != 0`;
  - `in_service` holds at most one bit;
  - RETI clears it.

## Test plan
- Reset, step 3 NEX with AW=15 -> `pc`=3; NEX with `hlt` -> `pc` stays 3; `pc`=0x7FFF then NEX -> `pc`=0.
- `pc`=4, CALL `target`=0x20 -> `pc`=0x20, `depth`=1, `ret_top`=5; RET -> `pc`=5, `depth`=0; RET again -> `pc`=6, `stk_unf`=1.
- DEPTH=2: three CALLs from `pc`=0 -> third call gives `pc+1` with `stk_ovf`=1 and `depth`=2; `clr_err` -> flag cleared.
- `pc`=0x10, `irq`=4'b0100 with a JMP op -> one cycle later `pc`=3 (VEC_BASE 1 + 2), `irq_ack`=0100, `ret_top`=0x10; RETI -> `pc`=0x10, `eoi`=1, `in_service`=0.
- Nest enabled: in ISR of channel 2, raise `irq[0]` -> accepted with `in_service`=0101; raise `irq[3]` -> held pending until both RETIs complete. Nest disabled: `irq[0]` is held until the first RETI.
- DI, then `irq[1]` -> no entry and `pending` kept; EI -> channel 1 accepted on the next step.
